// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with per-register busy scoreboard for issue hazard detection
module regfile_scoreboard #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter logic [XLEN-1:0] SP_INIT = 32'h0000_77FC,
    parameter bit BYPASS = 1'b1,
    localparam int unsigned AW = $clog2(NREG)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            issue_use_rs1,
    input  logic            issue_use_rs2,
    input  logic            flush,
    output logic            stall,
    output logic [NREG-1:0] busy_vec,
    output logic [AW:0]     pending_cnt
);
    localparam logic [NREG-1:0] ONE = 1;
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy, busy_eff, wb_vec, set_vec, clr_vec;
    logic            accept, set_any, clr_any, inc, dec;
    logic            wb_hit1, wb_hit2;

    // x0 is never written so it stays at its reset value of zero
    always_ff @(posedge clock or posedge reset)
        if (reset)
            for (int i = 0; i < NREG; i++) regs[i] <= (i == 2) ? SP_INIT : '0;
        else if (wb_en && wb_addr != '0)
            regs[wb_addr] <= wb_data;

    always_comb begin
        wb_hit1  = BYPASS && wb_en && wb_addr == rs1_addr;
        wb_hit2  = BYPASS && wb_en && wb_addr == rs2_addr;
        rs1_data = (rs1_addr == '0) ? '0 : wb_hit1 ? wb_data : regs[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : wb_hit2 ? wb_data : regs[rs2_addr];
        wb_vec   = (wb_en ? (ONE << wb_addr) : '0) & ~ONE;
        busy_eff = busy & ~(BYPASS ? wb_vec : '0);
        stall    = issue_valid && !flush && ((issue_use_rs1 && busy_eff[rs1_addr]) ||
                   (issue_use_rs2 && busy_eff[rs2_addr]) || busy_eff[issue_rd]);
        accept   = issue_valid && !stall && !flush;
        set_vec  = (accept ? (ONE << issue_rd) : '0) & ~ONE;
        clr_vec  = wb_vec & busy;
        set_any  = |set_vec;
        clr_any  = |clr_vec;
        inc      = set_any && !clr_any && pending_cnt != (AW+1)'(NREG-1);
        dec      = clr_any && !set_any && pending_cnt != '0;
        busy_vec = busy;
    end

    // set wins over clear so a same-cycle WB + reissue of one register stays busy
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else if (flush) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            busy        <= (busy & ~clr_vec) | set_vec;
            pending_cnt <= pending_cnt + (AW+1)'(inc) - (AW+1)'(dec);
        end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed stimulus with queued expectations checked by a negedge monitor
module tb_regfile_scoreboard;
    logic        clock = 0, reset = 1;
    logic [4:0]  rs1_addr = 0, rs2_addr = 0, wb_addr = 0, issue_rd = 0;
    logic [31:0] wb_data = 0;
    logic        wb_en = 0, issue_valid = 0, issue_use_rs1 = 0, issue_use_rs2 = 0, flush = 0;
    logic [31:0] rs1_data, rs2_data, rs1_nb, rs2_nb, busy_vec, busy_nb;
    logic        stall, stall_nb;
    logic [5:0]  pending_cnt, cnt_nb;

    typedef struct {int kind; logic [31:0] val; string name;} exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;

    regfile_scoreboard dut (
        .clock(clock), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2), .flush(flush),
        .stall(stall), .busy_vec(busy_vec), .pending_cnt(pending_cnt));

    regfile_scoreboard #(.BYPASS(1'b0)) dut_nb (
        .clock(clock), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_nb), .rs2_data(rs2_nb), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2), .flush(flush),
        .stall(stall_nb), .busy_vec(busy_nb), .pending_cnt(cnt_nb));

    always #5 clock = ~clock;

    function automatic logic [31:0] observe(input int k);
        case (k)
            0: return rs1_data;
            1: return rs2_data;
            2: return {31'b0, stall};
            3: return busy_vec;
            4: return {26'b0, pending_cnt};
            default: return rs1_nb;
        endcase
    endfunction

    always @(negedge clock)
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            act = observe(e.kind);
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.val, $time);
            end
        end

    task automatic expect_val(input int k, input logic [31:0] v, input string n);
        q.push_back('{k, v, n});
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_en = en; wb_addr = a; wb_data = d;
    endtask

    task automatic iss(input logic v, input logic [4:0] rd, input logic u1, input logic [4:0] r1);
        issue_valid = v; issue_rd = rd; issue_use_rs1 = u1; rs1_addr = r1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        cycle();
        reset = 0;
        expect_val(3, 0, "reset_busy");
        expect_val(4, 0, "reset_cnt");
        expect_val(2, 0, "reset_stall");
        for (int a = 0; a < 32; a++) begin
            cycle();
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            expect_val(0, (a == 2) ? 32'h0000_77FC : 32'h0, $sformatf("reset_rs1_x%0d", a));
            expect_val(1, (31 - a == 2) ? 32'h0000_77FC : 32'h0, $sformatf("reset_rs2_x%0d", 31 - a));
        end
        cycle();
        wb(1, 0, 32'hFFFF_FFFF); rs1_addr = 0;
        expect_val(0, 0, "x0_write_bypass");
        cycle();
        wb(0, 0, 0);
        expect_val(0, 0, "x0_after_write");
        cycle();
        wb(1, 5, 32'hDEAD_BEEF); rs1_addr = 5;
        expect_val(0, 32'hDEAD_BEEF, "bypass_x5");
        expect_val(5, 0, "nobypass_x5_old");
        cycle();
        wb(0, 0, 0);
        expect_val(0, 32'hDEAD_BEEF, "x5_after_edge");
        expect_val(5, 32'hDEAD_BEEF, "nobypass_x5_new");
        cycle();
        iss(1, 7, 0, 0);
        expect_val(2, 0, "issue_rd7_nostall");
        cycle();
        iss(1, 0, 1, 7);
        expect_val(2, 1, "raw_x7_stall");
        expect_val(4, 1, "cnt_after_rd7");
        expect_val(3, 32'h80, "busy_after_rd7");
        cycle();
        wb(1, 7, 32'h77);
        expect_val(2, 0, "raw_x7_bypass_release");
        expect_val(0, 32'h77, "raw_x7_data");
        cycle();
        wb(0, 0, 0); iss(0, 0, 0, 0);
        expect_val(4, 0, "cnt_after_wb7");
        expect_val(3, 0, "busy_after_wb7");
        cycle();
        iss(1, 9, 0, 0);
        expect_val(2, 0, "issue_rd9");
        cycle();
        expect_val(2, 1, "waw_x9_stall");
        expect_val(4, 1, "cnt_x9");
        cycle();
        wb(1, 9, 32'h99);
        expect_val(2, 0, "wb_and_issue_x9");
        cycle();
        wb(0, 0, 0); iss(0, 0, 0, 0);
        expect_val(3, 32'h200, "busy_x9_kept");
        expect_val(4, 1, "cnt_x9_unchanged");
        cycle();
        iss(1, 3, 0, 0);
        cycle();
        iss(1, 4, 0, 0);
        cycle();
        iss(1, 5, 0, 0);
        expect_val(2, 0, "issue_rd5");
        cycle();
        iss(0, 0, 0, 0);
        expect_val(4, 4, "cnt_four_pending");
        expect_val(3, 32'h238, "busy_four_pending");
        cycle();
        flush = 1; wb(1, 4, 32'h55); iss(1, 6, 0, 0);
        expect_val(2, 0, "flush_masks_stall");
        cycle();
        flush = 0; wb(0, 0, 0); iss(0, 0, 0, 4);
        expect_val(3, 0, "flush_busy");
        expect_val(4, 0, "flush_cnt");
        expect_val(0, 32'h55, "flush_wb_x4_lands");
        cycle();
        iss(1, 10, 0, 0);
        cycle();
        iss(1, 11, 0, 0);
        cycle();
        iss(1, 12, 0, 0);
        cycle();
        iss(0, 0, 0, 0);
        expect_val(4, 3, "cnt_three_pending");
        cycle();
        reset = 1; rs1_addr = 5; rs2_addr = 2;
        expect_val(3, 0, "async_reset_busy");
        expect_val(4, 0, "async_reset_cnt");
        expect_val(0, 0, "async_reset_x5");
        expect_val(1, 32'h0000_77FC, "async_reset_sp");
        cycle();
        reset = 0;
        cycle();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d queued expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
